// File: rtl/nios_system_myip_cpu_cpu_ocimem_arb.sv
// Arbiter between JTAG debug strobes and the Avalon debug-mem port for the
// single-port OCI debug RAM: one access at a time, round-robin on ties.
module nios_system_myip_cpu_cpu_ocimem_arb #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    typedef enum logic [1:0] {IDLE, WR, RD_A, RD_D} state_t;

    state_t            state, state_nxt;
    logic              jreq, jwrite;
    logic [31:0]       jwdata;
    logic [ADDR_W-1:0] jaddr;
    logic              gnt_jtag, gnt_jtag_nxt;
    logic              last_jtag, last_jtag_nxt;
    logic              av_req, pick_jtag, strobe, jdone;
    logic              jdo_unused;

    assign jdo_unused = ^{jdo[37:36], jdo[2:0]};
    assign av_req     = av_read | av_write;
    assign strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdone      = gnt_jtag && (state == WR || state == RD_D);

    // A tie goes to whichever source was not granted last.
    assign pick_jtag  = jreq && (!av_req || !last_jtag);

    always_comb begin
        state_nxt     = state;
        gnt_jtag_nxt  = gnt_jtag;
        last_jtag_nxt = last_jtag;
        case (state)
            IDLE: begin
                if (jreq || av_req) begin
                    gnt_jtag_nxt  = pick_jtag;
                    last_jtag_nxt = pick_jtag;
                    state_nxt     = (pick_jtag ? jwrite : av_write) ? WR : RD_A;
                end
            end
            WR:      state_nxt = IDLE;
            RD_A:    state_nxt = RD_D;
            RD_D:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt_jtag  <= 1'b0;
            last_jtag <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_jtag  <= gnt_jtag_nxt;
            last_jtag <= last_jtag_nxt;
        end
    end

    // Accepting a strobe needs jreq=0, so it can never coincide with jdone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jreq          <= 1'b0;
            jwrite        <= 1'b0;
            jwdata        <= '0;
            jaddr         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            if (jdone) begin
                jreq          <= 1'b0;
                monitor_ready <= 1'b1;
                jaddr         <= jaddr + ADDR_W'(1);
            end
            if (gnt_jtag && state == RD_D)
                MonDReg <= ram_rdata;
            if (strobe && jreq) begin
                monitor_error <= 1'b1;
            end else if (take_action_ocimem_a) begin
                monitor_error <= 1'b0;
                jaddr         <= jdo[17 +: ADDR_W];
                if (jdo[35]) begin
                    jreq          <= 1'b1;
                    jwrite        <= 1'b0;
                    monitor_ready <= 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                jreq          <= 1'b1;
                jwrite        <= 1'b1;
                jwdata        <= jdo[34:3];
                monitor_ready <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
                jreq          <= 1'b1;
                jwrite        <= 1'b0;
                monitor_ready <= 1'b0;
            end
        end
    end

    assign ram_wr         = (state == WR);
    assign ram_addr       = gnt_jtag ? jaddr  : av_address;
    assign ram_wdata      = gnt_jtag ? jwdata : av_writedata;
    assign av_readdata    = ram_rdata;
    assign av_waitrequest = !(!gnt_jtag && (state == WR || state == RD_D));

endmodule

// File: tb/tb_nios_system_myip_cpu_cpu_ocimem_arb.sv
// Bench for the OCI debug-mem arbiter: behavioural RAM plus an order-based
// reference memory and round-robin model checked against both ports.
module tb_nios_system_myip_cpu_cpu_ocimem_arb;
    logic        clk, reset_n;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata, av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        mem_clear;
    int          checks, errors;

    nios_system_myip_cpu_cpu_ocimem_arb #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .jdo(jdo), .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .ram_addr(ram_addr), .ram_wr(ram_wr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // kind 0: command strobe (val[7:0]=address, rd=jdo[35]); 1: write val; 2: read-next
    task automatic jstrobe(input int kind, input logic [31:0] val, input bit rd);
        logic [37:0] d;
        d = {6'($urandom), $urandom};
        if (kind == 0) begin
            d[24:17] = val[7:0];
            d[35]    = rd;
        end else if (kind == 1) begin
            d[34:3] = val;
        end
        jdo = d;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic av_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output bit ok);
        av_address   = a;
        av_writedata = d;
        av_write     = wr;
        av_read      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        ok = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 20 && !ok; i++) begin
            #1;
            if (!av_waitrequest) begin
                ok = 1'b1; lat = i; rd = av_readdata;
            end
            tick();
        end
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (monitor_ready) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        tick(); mem_clear = 1'b0; tick();
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", monitor_ready); end
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", monitor_error); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg got %h want 0", MonDReg); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr got %b want 0", ram_wr); end
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got %b want 1", av_waitrequest); end
        reset_n = 1'b1; tick();
        checks++; if (av_waitrequest !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL rst_release got wreq=%b wr=%b want 1/0", av_waitrequest, ram_wr); end
    endtask

    task automatic test_jtag_write();
        logic [31:0] v, rd; int lat; bit ok;
        jstrobe(0, 32'h10, 1'b0);
        jstrobe(1, 32'hDEADBEEF, 1'b0);
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL jw_ready_grant got %b want 0", monitor_ready); end
        tick();
        checks++; if ({ram_wr, ram_addr, ram_wdata} !== {1'b1, 8'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL jw_ram got wr=%b a=%h d=%h want 1/10/deadbeef", ram_wr, ram_addr, ram_wdata); end
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL jw_ready_wr got %b want 0", monitor_ready); end
        tick();
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL jw_ready_done got %b want 1", monitor_ready); end
        ref_mem[8'h10] = 32'hDEADBEEF;
        checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++; $display("FAIL jw_mem got %h want deadbeef", mem[8'h10]); end
        v = $urandom;
        av_xfer(1'b1, 8'h11, v, rd, lat, ok);
        ref_mem[8'h11] = v;
        checks++; if (!ok || lat != 2) begin errors++; $display("FAIL av_wr_lat got ok=%b lat=%0d want 1/2", ok, lat); end
        jstrobe(2, 32'h0, 1'b0);
        wait_ready(ok);
        checks++; if (!ok || MonDReg !== v) begin errors++; $display("FAIL jaddr_inc got ok=%b %h want %h", ok, MonDReg, v); end
    endtask

    task automatic test_wrap();
        logic [31:0] w, rd; int lat; bit ok1, ok2;
        w = $urandom;
        av_xfer(1'b1, 8'hFF, 32'h12345678, rd, lat, ok1);
        ref_mem[8'hFF] = 32'h12345678;
        av_xfer(1'b1, 8'h00, w, rd, lat, ok2);
        ref_mem[8'h00] = w;
        checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL wrap_preload got ok=%b%b want 11", ok1, ok2); end
        jstrobe(0, 32'hFF, 1'b0);
        jstrobe(2, 32'h0, 1'b0);
        wait_ready(ok1);
        checks++; if (!ok1 || MonDReg !== 32'h12345678) begin errors++; $display("FAIL wrap_read got ok=%b %h want 12345678", ok1, MonDReg); end
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", monitor_ready); end
        jstrobe(2, 32'h0, 1'b0);
        wait_ready(ok1);
        checks++; if (!ok1 || MonDReg !== w) begin errors++; $display("FAIL wrap_to_0 got ok=%b %h want %h", ok1, MonDReg, w); end
    endtask

    task automatic test_av_read();
        logic [31:0] rd; int lat; bit ok;
        av_xfer(1'b1, 8'h05, 32'hA5A5A5A5, rd, lat, ok);
        ref_mem[8'h05] = 32'hA5A5A5A5;
        av_xfer(1'b0, 8'h05, 32'h0, rd, lat, ok);
        checks++; if (!ok || lat != 3) begin errors++; $display("FAIL av_rd_lat got ok=%b lat=%0d want 1/3", ok, lat); end
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL av_rd_data got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_error();
        logic [31:0] d1, d2, d3, d4; bit ok;
        d1 = $urandom; d2 = ~d1; d3 = $urandom; d4 = ~d3;
        jstrobe(0, 32'h20, 1'b0);
        jstrobe(1, d1, 1'b0);
        jstrobe(1, d2, 1'b0);
        wait_ready(ok);
        ref_mem[8'h20] = d1;
        checks++; if (!ok || monitor_error !== 1'b1) begin errors++; $display("FAIL err_set got ok=%b err=%b want 1/1", ok, monitor_error); end
        checks++; if (mem[8'h20] !== d1 || mem[8'h21] !== ref_mem[8'h21]) begin errors++; $display("FAIL err_mem got %h %h want %h %h", mem[8'h20], mem[8'h21], d1, ref_mem[8'h21]); end
        tick(); tick(); tick();
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", monitor_error); end
        jstrobe(0, 32'h30, 1'b0);
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", monitor_error); end
        jstrobe(1, d3, 1'b0);
        tick();
        jstrobe(1, d4, 1'b0);
        wait_ready(ok);
        ref_mem[8'h30] = d3;
        checks++; if (!ok || monitor_error !== 1'b1) begin errors++; $display("FAIL err_completion got ok=%b err=%b want 1/1", ok, monitor_error); end
        checks++; if (mem[8'h30] !== d3 || mem[8'h31] !== ref_mem[8'h31]) begin errors++; $display("FAIL err_cmp_mem got %h %h want %h %h", mem[8'h30], mem[8'h31], d3, ref_mem[8'h31]); end
        jstrobe(0, 32'h40, 1'b0);
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL err_clear2 got %b want 0", monitor_error); end
    endtask

    // Round-robin model: the first tie after reset goes to JTAG, after that
    // whichever side was not granted most recently.
    task automatic test_tie();
        bit last_j, jfirst, jwr, awr, ok1, ok2;
        int jk, lat, exp_lat, nbad;
        logic [7:0] ja, aa;
        logic [31:0] jd, ad, rd, exp_rd, exp_mon;
        do_reset();
        last_j = 1'b0; ja = 8'h00;
        for (int r = 0; r < 100; r++) begin
            jk = $urandom_range(0, 2); jwr = (jk == 1); jd = $urandom;
            awr = 1'($urandom_range(0, 1)); aa = 8'($urandom); ad = $urandom;
            if (jk == 0) begin
                ja = 8'($urandom);
                jstrobe(0, {24'h0, ja}, 1'b1);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    ja = 8'($urandom);
                    jstrobe(0, {24'h0, ja}, 1'b0);
                end
                jstrobe(jk, jd, 1'b0);
            end
            jfirst = !last_j;
            exp_rd = '0; exp_mon = '0;
            if (jfirst) begin
                if (jwr) ref_mem[ja] = jd; else exp_mon = ref_mem[ja];
                if (awr) ref_mem[aa] = ad; else exp_rd = ref_mem[aa];
            end else begin
                if (awr) ref_mem[aa] = ad; else exp_rd = ref_mem[aa];
                if (jwr) ref_mem[ja] = jd; else exp_mon = ref_mem[ja];
            end
            ja++;
            last_j = !jfirst;
            exp_lat = jfirst ? 1 + (jwr ? 1 : 2) + (awr ? 2 : 3) : (awr ? 2 : 3);
            av_xfer(awr, aa, ad, rd, lat, ok1);
            wait_ready(ok2);
            checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL tie_starve r=%0d got av=%b j=%b want 1/1", r, ok1, ok2); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL tie_order r=%0d got lat=%0d want %0d", r, lat, exp_lat); end
            if (!awr) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL tie_av_rd r=%0d got %h want %h", r, rd, exp_rd); end
            end
            if (!jwr) begin
                checks++; if (MonDReg !== exp_mon) begin errors++; $display("FAIL tie_j_rd r=%0d got %h want %h", r, MonDReg, exp_mon); end
            end
            checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL tie_err r=%0d got %b want 0", r, monitor_error); end
        end
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        checks++; if (nbad != 0) begin errors++; $display("FAIL tie_mem got %0d bad words want 0", nbad); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, rd; int lat, wr_seen; bit ok;
        d = ~ref_mem[8'h50];
        jstrobe(0, 32'h50, 1'b0);
        jstrobe(1, d, 1'b0);
        tick();
        checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL mid_wr_state got %b want 1", ram_wr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({ram_wr, av_waitrequest, monitor_ready, monitor_error} !== 4'b0110) begin errors++; $display("FAIL mid_wr_async got %b want 0110", {ram_wr, av_waitrequest, monitor_ready, monitor_error}); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL mid_wr_mondreg got %h want 0", MonDReg); end
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (ram_wr !== 1'b0) wr_seen++; end
        checks++; if (wr_seen != 0) begin errors++; $display("FAIL mid_no_wr got %0d want 0", wr_seen); end
        reset_n = 1'b1; tick();
        checks++; if (mem[8'h50] !== ref_mem[8'h50]) begin errors++; $display("FAIL mid_mem got %h want %h", mem[8'h50], ref_mem[8'h50]); end
        av_address = 8'h05; av_read = 1'b1;
        tick();
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_rda_wreq got %b want 1", av_waitrequest); end
        #2 reset_n = 1'b0; av_read = 1'b0;
        #1;
        checks++; if (av_waitrequest !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL mid_rda_async got wreq=%b wr=%b want 1/0", av_waitrequest, ram_wr); end
        tick(); reset_n = 1'b1; tick();
        av_xfer(1'b0, 8'h05, 32'h0, rd, lat, ok);
        checks++; if (!ok || lat != 3 || rd !== ref_mem[8'h05]) begin errors++; $display("FAIL mid_idle got ok=%b lat=%0d %h want 1/3/%h", ok, lat, rd, ref_mem[8'h05]); end
        jstrobe(2, 32'h0, 1'b0);
        wait_ready(ok);
        checks++; if (!ok || monitor_error !== 1'b0 || MonDReg !== ref_mem[8'h00]) begin errors++; $display("FAIL mid_jreq_clr got ok=%b err=%b %h want 1/0/%h", ok, monitor_error, MonDReg, ref_mem[8'h00]); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; mem_clear = 1'b1;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        jdo = '0; av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
        test_reset();
        test_jtag_write();
        test_wrap();
        test_av_read();
        test_error();
        test_tie();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios_system_myip_cpu_cpu_ocimem_arb.md
NIOS_SYSTEM_MYIP_CPU_CPU_OCIMEM_ARB -- requirements
Module: nios_system_myIP_cpu_cpu_ocimem_arb

Interface
REQ-001 Parameter ADDR_W, default 8, debug RAM word-address width (2^ADDR_W x 32-bit words) SHALL be supported.
REQ-002 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  reset SHALL be asynchronous and active-low.
REQ-004 take_action_ocimem_a  input  1  JTAG command strobe: load jaddr and, if jdo[35]=1, request a read.
REQ-005 take_action_ocimem_b  input  1  JTAG write strobe: write jdo[34:3] to jaddr.
REQ-006 take_no_action_ocimem_a  input  1  JTAG read-next strobe: read at jaddr.
REQ-007 jdo  input  38  JTAG data from the debug slave sysclk stage.
REQ-008 av_address  input  ADDR_W; av_read  input  1; av_write  input  1; av_writedata  input  32  Avalon debug-mem request.
REQ-009 av_readdata  output  32; av_waitrequest  output  1  Avalon response.
REQ-010 ram_addr  output  ADDR_W; ram_wr  output  1; ram_wdata  output  32; ram_rdata  input  32  single-port RAM, read latency 1 cycle.
REQ-011 MonDReg  output  32; monitor_ready  output  1; monitor_error  output  1  JTAG-side status returned to the debug slave.

Function
REQ-012 Strobes SHALL be 1-cycle pulses; at most one JTAG strobe per cycle is expected; priority if several: ocimem_a > ocimem_b > no_action_ocimem_a.
REQ-013 On take_action_ocimem_a, jaddr SHALL load jdo[17 +: ADDR_W]; a JTAG read request SHALL be posted only if jdo[35]=1.
REQ-014 take_action_ocimem_b SHALL post a JTAG write of jdo[34:3]; take_no_action_ocimem_a SHALL post a JTAG read.
REQ-015 Each accepted JTAG strobe SHALL set jreq and clear monitor_ready next cycle.
REQ-016 A JTAG strobe arriving while jreq=1 SHALL be dropped and set monitor_error; monitor_error SHALL be sticky until the next take_action_ocimem_a, which clears it (and is itself accepted only if jreq=0).
REQ-017 FSM states: IDLE, WR, RD_A, RD_D.
REQ-018 IDLE: if exactly one of jreq / Avalon request pending, grant it; if both, grant the source not granted last (round-robin, last_grant register); go WR for writes, RD_A for reads.
REQ-019 av_read and av_write both high SHALL be treated as a write.
REQ-020 WR (1 cycle): ram_wr=1, ram_addr/ram_wdata from granted source; next state IDLE.
REQ-021 RD_A (1 cycle): ram_addr from granted source, ram_wr=0; next RD_D.
REQ-022 RD_D (1 cycle): ram_rdata valid; Avalon grant: av_readdata=ram_rdata; JTAG grant: MonDReg loads ram_rdata at the clock edge; next IDLE.
REQ-023 av_waitrequest SHALL be 0 only in WR or RD_D when Avalon is granted, else 1; Avalon master holds its request while waitrequest=1.
REQ-024 JTAG completion (end of WR or RD_D) SHALL clear jreq, set monitor_ready, and increment jaddr modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0).
REQ-025 Latency from grant in IDLE: write 2 cycles, read 3 cycles; back-to-back grants SHALL return through IDLE (no combined cycles).
REQ-026 Strobes arriving during a grant to Avalon SHALL be accepted (jreq set) if jreq=0; a strobe arriving in the JTAG completion cycle SHALL be treated as jreq=1 (dropped, error).
REQ-027 ram_wr SHALL never be asserted outside WR; av_readdata outside RD_D is don't-care.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, jreq=0, jaddr=0, MonDReg=0, monitor_ready=1, monitor_error=0, last_grant=Avalon (so JTAG wins first tie), ram_wr=0, av_waitrequest=1.
REQ-029 Reset asserted mid-operation SHALL abort the access with no RAM write after assertion; pending requests are discarded.

Verification
REQ-030 take_action_ocimem_a jdo[17+:8]=0x10, jdo[35]=0; then take_action_ocimem_b jdo[34:3]=0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, monitor_ready high 2 cycles after grant, jaddr=0x11.
REQ-031 jaddr=0xFF, take_no_action_ocimem_a with RAM[0xFF]=0x12345678 -> MonDReg=0x12345678, monitor_ready=1, jaddr wraps to 0x00.
REQ-032 av_read addr 0x05 (RAM=0xA5A5A5A5) with no JTAG traffic -> av_waitrequest low exactly in 3rd cycle, av_readdata=0xA5A5A5A5.
REQ-033 JTAG write and Avalon write pending same cycle after reset -> JTAG granted first, Avalon next; repeat tie -> Avalon first; no starvation over 100 random tie cycles.
REQ-034 Second take_action_ocimem_b while jreq=1 -> dropped, monitor_error=1 until next take_action_ocimem_a; RAM unchanged by dropped strobe.
REQ-035 reset_n low during WR/RD_A -> outputs at reset values immediately, no ram_wr after assertion, FSM in IDLE on release.
